// File: rtl/modn_updown_counter_if.sv
// Bus for one modulo-N up/down counter stage. The master drives the controls.
// The slave (the counter) returns the count and its status flags.
interface modn_updown_counter_if #(
    parameter int WIDTH = 6
);
    logic             enable;
    logic             up;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             tc;
    logic             load_err;
    logic [7:0]       bcd;

    modport master (
        output enable, up, clear, load, load_value,
        input  count, carry_out, tc, load_err, bcd
    );

    modport slave (
        input  enable, up, clear, load, load_value,
        output count, carry_out, tc, load_err, bcd
    );
endinterface

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter stage with synchronous clear/load and cascade carry.
// Optional registered BCD view of the count when MODN_BCD_OUT_EN is defined.
module modn_updown_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    modn_updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    if (MODULUS < 2) begin : g_bad_modulus
        $error("modn_updown_counter: MODULUS must be >= 2");
    end
    if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
        $error("modn_updown_counter: WIDTH too small for MODULUS");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             load_err_q, load_err_d;
    logic             tc_s;
    logic             carry_s;

    // Next count and load error, honouring clear > load > enable.
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (bus.clear) begin
            count_d = ZERO_C;
        end else if (bus.load) begin
            if (bus.load_value > MAX_C) begin
                count_d    = MAX_C;
                load_err_d = 1'b1;
            end else begin
                count_d = bus.load_value;
            end
        end else if (bus.enable) begin
            // An upset code outside the range recovers to zero in either direction.
            if (count_q > MAX_C) begin
                count_d = ZERO_C;
            end else if (bus.up) begin
                count_d = (count_q == MAX_C) ? ZERO_C : (count_q + ONE_C);
            end else begin
                count_d = (count_q == ZERO_C) ? MAX_C : (count_q - ONE_C);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Terminal count and cascade carry, zero latency.
    always_comb begin
        tc_s    = bus.up ? (count_q == MAX_C) : (count_q == ZERO_C);
        carry_s = tc_s & bus.enable & ~bus.clear & ~bus.load;
    end

    // Count and load-error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= ZERO_C;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef MODN_BCD_OUT_EN
    if (MODULUS > 100) begin : g_bad_bcd
        $error("modn_updown_counter: BCD output needs MODULUS <= 100");
    end

    logic [7:0] bcd_q, bcd_d;
    logic [7:0] next8_s;

    // Convert the next count so the BCD view lands on the same edge as count.
    always_comb begin
        next8_s = 8'(count_d);
        bcd_d   = {4'(next8_s / 8'd10), 4'(next8_s % 8'd10)};
    end

    // BCD register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.bcd = bcd_q;
`else
    assign bus.bcd = 8'h00;
`endif

    assign bus.count     = count_q;
    assign bus.load_err  = load_err_q;
    assign bus.tc        = tc_s;
    assign bus.carry_out = carry_s;
endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench: mod-60 stage cascaded into a mod-24 stage through carry_out.
module tb_modn_updown_counter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    modn_updown_counter_if #(.WIDTH(6)) bus0 ();
    modn_updown_counter_if #(.WIDTH(5)) bus1 ();

    assign bus1.enable = bus0.carry_out;

    modn_updown_counter #(.MODULUS(60), .WIDTH(6)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    modn_updown_counter #(.MODULUS(24), .WIDTH(5)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_bcd(input int v);
`ifdef MODN_BCD_OUT_EN
        return {4'(v / 10), 4'(v % 10)};
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst             = 1'b1;
        bus0.enable     = 1'b0;
        bus0.up         = 1'b1;
        bus0.clear      = 1'b0;
        bus0.load       = 1'b0;
        bus0.load_value = 6'd0;
        bus1.up         = 1'b1;
        bus1.clear      = 1'b0;
        bus1.load       = 1'b0;
        bus1.load_value = 5'd0;

        // Reset state
        #12;
        chk("rst_count", bus0.count, 0);
        chk("rst_load_err", bus0.load_err, 0);
        chk("rst_bcd", bus0.bcd, 0);
        chk("rst_tc", bus0.tc, 0);
        chk("rst_carry", bus0.carry_out, 0);
        chk("rst_s1_count", bus1.count, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1. Count up through a full wrap
        bus0.enable = 1'b1;
        bus0.up     = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            chk("up_count", bus0.count, i);
            chk("up_carry", bus0.carry_out, (i == 59) ? 1 : 0);
            chk("up_bcd", bus0.bcd, exp_bcd(i));
            tick();
        end
        chk("up_wrap_count", bus0.count, 0);
        chk("up_wrap_s1", bus1.count, 1);

        // 2. Down wrap from 0
        bus0.enable     = 1'b0;
        bus0.load       = 1'b1;
        bus0.load_value = 6'd0;
        tick();
        chk("ld0_count", bus0.count, 0);
        chk("ld0_s1", bus1.count, 1);
        bus0.load   = 1'b0;
        bus0.enable = 1'b1;
        bus0.up     = 1'b0;
        #1;
        chk("dn_tc", bus0.tc, 1);
        chk("dn_carry", bus0.carry_out, 1);
        tick();
        chk("dn_wrap_count", bus0.count, 59);
        chk("dn_wrap_bcd", bus0.bcd, exp_bcd(59));
        chk("dn_wrap_s1", bus1.count, 2);
        chk("dn_59_tc", bus0.tc, 0);
        bus0.enable = 1'b0;
        bus0.up     = 1'b1;
        #1;
        chk("dir_tc_ungated", bus0.tc, 1);
        chk("dir_carry_gated", bus0.carry_out, 0);
        bus0.enable = 1'b1;
        #1;
        chk("dir_carry_up", bus0.carry_out, 1);
        bus0.enable = 1'b0;
        bus0.up     = 1'b0;
        #1;
        chk("dir_tc_down", bus0.tc, 0);

        // 3. Out-of-range and in-range loads
        bus0.load       = 1'b1;
        bus0.load_value = 6'd63;
        tick();
        chk("ld63_count", bus0.count, 59);
        chk("ld63_err", bus0.load_err, 1);
        bus0.load = 1'b0;
        tick();
        chk("ld63_err_drop", bus0.load_err, 0);
        chk("ld63_hold", bus0.count, 59);
        bus0.load       = 1'b1;
        bus0.load_value = 6'd42;
        tick();
        chk("ld42_count", bus0.count, 42);
        chk("ld42_err", bus0.load_err, 0);
        chk("ld42_bcd", bus0.bcd, exp_bcd(42));
        bus0.load = 1'b0;
        tick();
        chk("hold_count", bus0.count, 42);
        bus0.load       = 1'b1;
        bus0.load_value = 6'd60;
        tick();
        chk("ld60_count", bus0.count, 59);
        chk("ld60_err", bus0.load_err, 1);
        bus0.load_value = 6'd59;
        tick();
        chk("ld59_count", bus0.count, 59);
        chk("ld59_err", bus0.load_err, 0);

        // 4. Priority clear > load > enable
        bus0.clear      = 1'b1;
        bus0.load       = 1'b1;
        bus0.enable     = 1'b1;
        bus0.up         = 1'b1;
        bus0.load_value = 6'd10;
        #1;
        chk("pri_tc", bus0.tc, 1);
        chk("pri_carry", bus0.carry_out, 0);
        tick();
        chk("pri_clear_count", bus0.count, 0);
        chk("pri_clear_err", bus0.load_err, 0);
        bus0.clear = 1'b0;
        tick();
        chk("pri_load_count", bus0.count, 10);
        bus0.clear      = 1'b1;
        bus0.load_value = 6'd63;
        tick();
        chk("pri_clr63_count", bus0.count, 0);
        chk("pri_clr63_err", bus0.load_err, 0);
        chk("pri_s1", bus1.count, 2);
        bus0.clear  = 1'b0;
        bus0.load   = 1'b0;
        bus0.enable = 1'b0;

        // 5. Asynchronous reset mid-count
        bus0.load       = 1'b1;
        bus0.load_value = 6'd36;
        tick();
        bus0.load   = 1'b0;
        bus0.enable = 1'b1;
        tick();
        chk("ar_pre_count", bus0.count, 37);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_count", bus0.count, 0);
        chk("ar_bcd", bus0.bcd, 0);
        chk("ar_s1", bus1.count, 0);
        tick();
        chk("ar_held", bus0.count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_resume", bus0.count, 1);

        // 6. Cascade 60 x 24 over a full day of steps
        bus0.enable = 1'b0;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        bus0.enable = 1'b1;
        bus0.up     = 1'b1;
        #1;
        for (int n = 0; n < 1440; n++) begin
            chk("cas_s0", bus0.count, n % 60);
            chk("cas_s1", bus1.count, (n / 60) % 24);
            chk("cas_s1_carry", bus1.carry_out, (n == 1439) ? 1 : 0);
            if (n == 1439) begin
                chk("cas_s1_bcd", bus1.bcd, exp_bcd(23));
            end
            tick();
        end
        chk("cas_end_s0", bus0.count, 0);
        chk("cas_end_s1", bus1.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
